// File: rtl/rf_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_read_arbiter
// Brief    : Round-robin arbiter for four requesters sharing one register-bank
//            read mux; grant, capture, respond in a two-cycle pipeline.
// Revision : 1.0
// ============================================================================
module rf_read_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        req,
   input  logic [19:0]       addr_in,
   output logic [3:0]        gnt,
   output logic [4:0]        mux_sel,
   input  logic [DATA_W-1:0] mux_dout,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic [1:0]        rid,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic [1:0]        r_ptr;
   logic [1:0]        r_owner;
   logic [3:0]        r_gnt;
   logic [4:0]        r_mux_sel;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic [1:0]        r_rid;

   logic [1:0]        w_start;
   logic [1:0]        w_idx;
   logic [1:0]        w_win;
   logic              w_found;
   logic [4:0]        w_addr;

   // In RESP the search starts past the current owner, i.e. the pointer value
   // that is being written back this very cycle.
   assign w_start = (r_state == S_RESP) ? r_owner + 2'd1 : r_ptr;

   always_comb begin
      w_win   = 2'd0;
      w_found = 1'b0;
      w_idx   = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = w_start + 2'(k);
         if (req[w_idx]) begin
            w_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      case (w_win)
         2'd0:    w_addr = addr_in[4:0];
         2'd1:    w_addr = addr_in[9:5];
         2'd2:    w_addr = addr_in[14:10];
         default: w_addr = addr_in[19:15];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_owner   <= 2'd0;
         r_gnt     <= 4'd0;
         r_mux_sel <= 5'd0;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
         r_rid     <= 2'd0;
      end else begin
         r_gnt    <= 4'd0;
         r_rvalid <= 1'b0;
         case (r_state)
            S_IDLE, S_RESP: begin
               if (r_state == S_RESP) begin
                  r_ptr <= r_owner + 2'd1;
               end
               if (w_found) begin
                  r_owner   <= w_win;
                  r_mux_sel <= w_addr;
                  r_gnt     <= 4'b0001 << w_win;
                  r_state   <= S_READ;
               end else begin
                  r_state   <= S_IDLE;
               end
            end
            S_READ: begin
               r_rdata  <= mux_dout;
               r_rvalid <= 1'b1;
               r_rid    <= r_owner;
               r_state  <= S_RESP;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign mux_sel = r_mux_sel;
   assign rdata   = r_rdata;
   assign rvalid  = r_rvalid;
   assign rid     = r_rid;
   assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/rf_read_arbiter.md
RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of register-bank read data; requester count is fixed at 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester read request; bit i = requester i.
REQ-005 addr_in  input  20  requester i read address at bits [5i+4:5i].
REQ-006 gnt  output  4  one-hot grant pulse; bit i = requester i accepted.
REQ-007 mux_sel  output  5  select driven to the 32-to-1 read mux.
REQ-008 mux_dout  input  DATA_W  combinational mux output for the current mux_sel.
REQ-009 rdata  output  DATA_W  captured read data.
REQ-010 rvalid  output  1  rdata/rid valid, one-cycle pulse.
REQ-011 rid  output  2  index of the requester that owns rdata.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, READ, RESP.
REQ-014 IDLE: if req != 0, pick the winner by round-robin starting at ptr (ptr, ptr+1, ... mod 4), latch owner and the owner's addr_in slice, go READ; else stay IDLE.
REQ-015 READ: mux_sel = latched address; gnt[owner] = 1 for exactly this cycle; at the end of the cycle, capture mux_dout into rdata; go RESP.
REQ-016 RESP: rvalid = 1, rid = owner for exactly this cycle; ptr <= owner+1 mod 4.
REQ-017 RESP: req is re-arbitrated in the same cycle using the updated pointer value (owner+1). Any req -> latch the new winner and go READ back-to-back. Otherwise go IDLE.
REQ-018 Latency: req sampled high in IDLE at edge N -> gnt high in cycle N+1 -> rvalid high in cycle N+2.
REQ-019 Sustained throughput SHALL be one read per 2 cycles.
REQ-020 Handshake: a requester SHALL hold req and addr_in stable until it samples its gnt bit. A req still high in RESP is treated as a new request.
REQ-021 Req changes outside IDLE/RESP arbitration points SHALL have no effect; the latched address SHALL not change during READ.
REQ-022 gnt SHALL be one-hot or zero. It is nonzero only in READ.
REQ-023 rvalid SHALL be high only in RESP. rdata and rid SHALL hold their last values otherwise.
REQ-024 mux_sel SHALL hold its last driven value in IDLE and RESP unless a new address is latched.
REQ-025 Round-robin SHALL guarantee that any continuously asserted req is granted within 4 grants.
REQ-026 Simultaneous requests SHALL be resolved solely by ptr order; there is no fixed priority.
REQ-027 All 32 addresses (0-31) SHALL be legal; there is no error condition.

Reset
REQ-028 reset high at a rising edge SHALL force IDLE from any state, including mid-READ or RESP; an in-flight transaction is dropped with no rvalid.
REQ-029 Reset values: ptr=0, owner=0, gnt=0, rvalid=0, rid=0, rdata=0, mux_sel=0, busy=0.
REQ-030 On the first edge with reset low, normal arbitration SHALL resume from IDLE with ptr=0.

Verification
REQ-031 Single read: req=4'b0001, addr0=5'd7, mux model returns 32'h0000_0007+k for sel k -> gnt=0001 at N+1, mux_sel=7, rvalid at N+2 with rdata=32'h0000_000E, rid=0.
REQ-032 Contention: req=4'b1111 held continuously, addresses 1/2/3/4 -> grants in order 0,1,2,3,0 in consecutive READ cycles, rvalid every 2 cycles, with no IDLE between.
REQ-033 Fairness: ptr=2 after serving requester 1, then req=4'b0011 -> requester 0 is granted before requester 1 is granted again.
REQ-034 Back-to-back: requester 3 (addr=31) is served; requester 2 (addr=0) raises req during RESP -> READ follows immediately with mux_sel=0 and rid=2 on the next rvalid.
REQ-035 Reset mid-op: reset asserted during READ -> next cycle busy=0, rvalid=0, gnt=0, mux_sel=0; with req=4'b1000 then applied, requester 3 is granted normally.
REQ-036 Idle hold: req=0 for 10 cycles after a read -> gnt=0, rvalid=0, rdata and mux_sel unchanged.
